// File: rtl/register_xfer_counter_if.sv
// Bus bundle for register_xfer_counter: addr/xfer/main bus data, active-low
// controls and the value/enable/status outputs.
// REGISTER_XFER_SHADOW_EN adds the active-low save/restore controls.
interface register_xfer_counter_if #(
    parameter int WIDTH_AX   = 16,
    parameter int WIDTH_MAIN = 8
);
    localparam int LANES = WIDTH_AX / WIDTH_MAIN;
    localparam int LSEL  = (LANES > 1) ? $clog2(LANES) : 1;

    logic [WIDTH_AX-1:0]   addr_in;
    logic [WIDTH_AX-1:0]   xfer_in;
    logic [WIDTH_MAIN-1:0] main_in;
    logic [LSEL-1:0]       lane_sel;
    logic                  load_xfer;
    logic                  load_addr;
    logic                  load_main;
    logic                  inc;
    logic                  dec;
    logic                  assert_addr;
    logic                  assert_xfer;
    logic                  assert_main;
`ifdef REGISTER_XFER_SHADOW_EN
    logic                  save;
    logic                  restore;
`endif
    logic [WIDTH_AX-1:0]   addr_out;
    logic [WIDTH_AX-1:0]   xfer_out;
    logic [WIDTH_MAIN-1:0] main_out;
    logic                  addr_en;
    logic                  xfer_en;
    logic                  main_en;
    logic                  zero;
    logic                  wrap;

`ifdef REGISTER_XFER_SHADOW_EN
    modport master (
        output addr_in, xfer_in, main_in, lane_sel,
        output load_xfer, load_addr, load_main, inc, dec,
        output assert_addr, assert_xfer, assert_main, save, restore,
        input  addr_out, xfer_out, main_out, addr_en, xfer_en, main_en, zero, wrap
    );
    modport slave (
        input  addr_in, xfer_in, main_in, lane_sel,
        input  load_xfer, load_addr, load_main, inc, dec,
        input  assert_addr, assert_xfer, assert_main, save, restore,
        output addr_out, xfer_out, main_out, addr_en, xfer_en, main_en, zero, wrap
    );
`else
    modport master (
        output addr_in, xfer_in, main_in, lane_sel,
        output load_xfer, load_addr, load_main, inc, dec,
        output assert_addr, assert_xfer, assert_main,
        input  addr_out, xfer_out, main_out, addr_en, xfer_en, main_en, zero, wrap
    );
    modport slave (
        input  addr_in, xfer_in, main_in, lane_sel,
        input  load_xfer, load_addr, load_main, inc, dec,
        input  assert_addr, assert_xfer, assert_main,
        output addr_out, xfer_out, main_out, addr_en, xfer_en, main_en, zero, wrap
    );
`endif
endinterface

// File: rtl/register_xfer_counter.sv
// Transfer register with whole-word loads from the xfer/addr buses, byte-lane
// loads from the main bus, and up/down counting by STEP with a one-cycle wrap
// pulse. Serves as PC, SP or pointer register.
// Optional feature: define REGISTER_XFER_SHADOW_EN for a shadow copy with
// active-low save/restore (restore ranks just below reset).
// WIDTH_AX must be a multiple of WIDTH_MAIN.
module register_xfer_counter #(
    parameter int                  WIDTH_AX      = 16,
    parameter int                  WIDTH_MAIN    = 8,
    parameter logic [WIDTH_AX-1:0] DEFAULT_VALUE = '0,
    parameter int                  STEP          = 1
) (
    input logic                    clk,
    input logic                    reset,
    register_xfer_counter_if.slave bus
);
    localparam int LANES = WIDTH_AX / WIDTH_MAIN;
    localparam int LSEL  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [WIDTH_AX:0] STEP_X = (WIDTH_AX+1)'(STEP);

    typedef logic [LANES-1:0][WIDTH_MAIN-1:0] lanes_t;

    lanes_t            value_q;
    lanes_t            value_d;
    lanes_t            lane_merge;
    logic              wrap_q;
    logic              wrap_d;
    logic [WIDTH_AX:0] sum_x;
    logic [WIDTH_AX:0] diff_x;
`ifdef REGISTER_XFER_SHADOW_EN
    lanes_t            shadow_q;
`endif

    // Extra top bit catches carry-out on inc and borrow on dec.
    assign sum_x  = {1'b0, value_q} + STEP_X;
    assign diff_x = {1'b0, value_q} - STEP_X;

    // Main-bus write touches only the selected lane; an out-of-range lane_sel matches nothing.
    always_comb begin
        lane_merge = value_q;
        for (int l = 0; l < LANES; l++) begin
            if (bus.lane_sel == LSEL'(l)) lane_merge[l] = bus.main_in;
        end
    end

    // Next value by priority; wrap only ever set by a lone inc or dec.
    always_comb begin
        value_d = value_q;
        wrap_d  = 1'b0;
`ifdef REGISTER_XFER_SHADOW_EN
        if (!bus.restore)
            value_d = shadow_q;
        else
`endif
        if (!bus.load_xfer)
            value_d = bus.xfer_in;
        else if (!bus.load_addr)
            value_d = bus.addr_in;
        else if (!bus.load_main)
            value_d = lane_merge;
        else if (!bus.inc && bus.dec) begin
            value_d = sum_x[WIDTH_AX-1:0];
            wrap_d  = sum_x[WIDTH_AX];
        end else if (!bus.dec && bus.inc) begin
            value_d = diff_x[WIDTH_AX-1:0];
            wrap_d  = diff_x[WIDTH_AX];
        end
    end

    // Value and wrap registers; reset overrides every control.
    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= DEFAULT_VALUE;
            wrap_q  <= 1'b0;
        end else begin
            value_q <= value_d;
            wrap_q  <= wrap_d;
        end
    end

`ifdef REGISTER_XFER_SHADOW_EN
    // Shadow captures the pre-edge value, so save+restore together swaps.
    always_ff @(posedge clk) begin
        if (reset)
            shadow_q <= DEFAULT_VALUE;
        else if (!bus.save)
            shadow_q <= value_q;
    end
`endif

    // Read the selected lane; out-of-range lane_sel reads as zero.
    always_comb begin
        bus.main_out = '0;
        for (int l = 0; l < LANES; l++) begin
            if (bus.lane_sel == LSEL'(l)) bus.main_out = value_q[l];
        end
    end

    assign bus.addr_out = value_q;
    assign bus.xfer_out = value_q;
    assign bus.addr_en  = ~bus.assert_addr;
    assign bus.xfer_en  = ~bus.assert_xfer;
    assign bus.main_en  = ~bus.assert_main;
    assign bus.zero     = (value_q == '0);
    assign bus.wrap     = wrap_q;
endmodule

// File: tb/tb_register_xfer_counter.sv
// Bench for register_xfer_counter: two instances (STEP=1 and STEP=2) share one
// stimulus stream; a reference model pushes expected results into a scoreboard
// before each edge and they are popped and compared after it.
module tb_register_xfer_counter;
    localparam logic [15:0] DEF = 16'h1234;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] addr_in = '0, xfer_in = '0;
    logic [7:0]  main_in = '0;
    logic        lane_sel = 1'b0;
    logic        load_xfer = 1'b1, load_addr = 1'b1, load_main = 1'b1;
    logic        inc = 1'b1, dec = 1'b1;
    logic        assert_addr = 1'b1, assert_xfer = 1'b1, assert_main = 1'b1;
    logic        save_n = 1'b1, restore_n = 1'b1;

    always #5 clk = ~clk;

    register_xfer_counter_if #(.WIDTH_AX(16), .WIDTH_MAIN(8)) ifa ();
    register_xfer_counter_if #(.WIDTH_AX(16), .WIDTH_MAIN(8)) ifb ();

    assign ifa.addr_in = addr_in;        assign ifb.addr_in = addr_in;
    assign ifa.xfer_in = xfer_in;        assign ifb.xfer_in = xfer_in;
    assign ifa.main_in = main_in;        assign ifb.main_in = main_in;
    assign ifa.lane_sel = lane_sel;      assign ifb.lane_sel = lane_sel;
    assign ifa.load_xfer = load_xfer;    assign ifb.load_xfer = load_xfer;
    assign ifa.load_addr = load_addr;    assign ifb.load_addr = load_addr;
    assign ifa.load_main = load_main;    assign ifb.load_main = load_main;
    assign ifa.inc = inc;                assign ifb.inc = inc;
    assign ifa.dec = dec;                assign ifb.dec = dec;
    assign ifa.assert_addr = assert_addr; assign ifb.assert_addr = assert_addr;
    assign ifa.assert_xfer = assert_xfer; assign ifb.assert_xfer = assert_xfer;
    assign ifa.assert_main = assert_main; assign ifb.assert_main = assert_main;
`ifdef REGISTER_XFER_SHADOW_EN
    assign ifa.save = save_n;            assign ifb.save = save_n;
    assign ifa.restore = restore_n;      assign ifb.restore = restore_n;
`endif

    register_xfer_counter #(.WIDTH_AX(16), .WIDTH_MAIN(8), .DEFAULT_VALUE(DEF), .STEP(1))
        dut_a (.clk(clk), .reset(reset), .bus(ifa));
    register_xfer_counter #(.WIDTH_AX(16), .WIDTH_MAIN(8), .DEFAULT_VALUE(DEF), .STEP(2))
        dut_b (.clk(clk), .reset(reset), .bus(ifb));

    typedef struct {
        string       tag;
        logic [15:0] val;
        logic        wrap;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [15:0] m_val[2] = '{DEF, DEF};
    logic [15:0] m_sh[2]  = '{DEF, DEF};
    logic        m_wrap[2] = '{1'b0, 1'b0};
    int          steps[2] = '{1, 2};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model for one clock edge, using integer arithmetic.
    task automatic model_edge(input string tag);
        int s;
        logic [15:0] nsh;
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_val[i] = DEF; m_sh[i] = DEF; m_wrap[i] = 1'b0;
            end else begin
                nsh = !save_n ? m_val[i] : m_sh[i];
                m_wrap[i] = 1'b0;
                if (!restore_n)      m_val[i] = m_sh[i];
                else if (!load_xfer) m_val[i] = xfer_in;
                else if (!load_addr) m_val[i] = addr_in;
                else if (!load_main) begin
                    if (lane_sel) m_val[i][15:8] = main_in;
                    else          m_val[i][7:0]  = main_in;
                end else if (!inc && dec) begin
                    s = int'(m_val[i]) + steps[i];
                    m_wrap[i] = (s >= 65536);
                    m_val[i] = 16'(s % 65536);
                end else if (!dec && inc) begin
                    s = int'(m_val[i]) - steps[i];
                    m_wrap[i] = (s < 0);
                    if (s < 0) s += 65536;
                    m_val[i] = 16'(s);
                end
                m_sh[i] = nsh;
            end
            sb.push_back('{tag, m_val[i], m_wrap[i]});
        end
    endtask

    task automatic cycle(input string tag);
        exp_t e;
        model_edge(tag);
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            e = sb.pop_front();
            chk($sformatf("%s[%0d]/addr_out", e.tag, i), i ? ifb.addr_out : ifa.addr_out, e.val);
            chk($sformatf("%s[%0d]/xfer_out", e.tag, i), i ? ifb.xfer_out : ifa.xfer_out, e.val);
            chk($sformatf("%s[%0d]/wrap", e.tag, i), i ? ifb.wrap : ifa.wrap, e.wrap);
            chk($sformatf("%s[%0d]/zero", e.tag, i), i ? ifb.zero : ifa.zero, e.val == 16'h0);
        end
    endtask

    // Combinational outputs against the model's current value.
    task automatic chk_comb(input string tag);
        logic [7:0] exp_main;
        for (int i = 0; i < 2; i++) begin
            exp_main = lane_sel ? m_val[i][15:8] : m_val[i][7:0];
            chk($sformatf("%s[%0d]/main_out", tag, i), i ? ifb.main_out : ifa.main_out, exp_main);
            chk($sformatf("%s[%0d]/main_en", tag, i), i ? ifb.main_en : ifa.main_en, !assert_main);
            chk($sformatf("%s[%0d]/addr_en", tag, i), i ? ifb.addr_en : ifa.addr_en, !assert_addr);
            chk($sformatf("%s[%0d]/xfer_en", tag, i), i ? ifb.xfer_en : ifa.xfer_en, !assert_xfer);
        end
    endtask

    initial begin
        // Reset with an assert active: enables follow the asserts during reset.
        reset = 1'b1; assert_addr = 1'b0;
        cycle("reset");
        chk_comb("reset_en");
        reset = 1'b0; assert_addr = 1'b1;

        // xfer beats addr in the same cycle.
        load_xfer = 1'b0; xfer_in = 16'hBEEF; load_addr = 1'b0; addr_in = 16'h1111;
        cycle("xfer_wins");
        load_xfer = 1'b1; addr_in = 16'h00FF;
        cycle("load_addr");
        load_addr = 1'b1;

        // Upper lane write, then read both lanes onto the main bus.
        lane_sel = 1'b1; load_main = 1'b0; main_in = 8'hA5;
        cycle("lane1_wr");
        load_main = 1'b1; assert_main = 1'b0; #1;
        chk_comb("lane1_rd");
        lane_sel = 1'b0; assert_xfer = 1'b0; #1;
        chk_comb("lane0_rd");
        assert_main = 1'b1; assert_xfer = 1'b1;

        // Increment across the top, then wrap clears.
        load_xfer = 1'b0; xfer_in = 16'hFFFF;
        cycle("load_ffff");
        load_xfer = 1'b1; inc = 1'b0;
        cycle("inc_wrap");
        inc = 1'b1;
        cycle("wrap_clear");

        // Decrement below zero.
        load_xfer = 1'b0; xfer_in = 16'h0001;
        cycle("load_0001");
        load_xfer = 1'b1; dec = 1'b0;
        cycle("dec_wrap");
        inc = 1'b0;
        cycle("inc_dec_both");
        dec = 1'b1;

        // A load beats a pending inc and suppresses wrap.
        load_xfer = 1'b0; xfer_in = 16'hFFFF;
        cycle("load_over_inc");
        load_xfer = 1'b1;
        cycle("inc_after_load");

        // Reset in the middle of counting overrides everything.
        reset = 1'b1; load_xfer = 1'b0; load_main = 1'b0;
        cycle("reset_mid");
        reset = 1'b0; load_xfer = 1'b1; load_main = 1'b1; inc = 1'b1;

`ifdef REGISTER_XFER_SHADOW_EN
        load_xfer = 1'b0; xfer_in = 16'h0042;
        cycle("sh_load42");
        load_xfer = 1'b1; save_n = 1'b0;
        cycle("sh_save");
        save_n = 1'b1; load_xfer = 1'b0; xfer_in = 16'h0007;
        cycle("sh_load7");
        load_xfer = 1'b1; restore_n = 1'b0;
        cycle("sh_restore");
        restore_n = 1'b1; load_xfer = 1'b0; xfer_in = 16'h0007;
        cycle("sh_load7b");
        load_xfer = 1'b1; save_n = 1'b0; restore_n = 1'b0;
        cycle("sh_swap");
        save_n = 1'b1;
        cycle("sh_swap_back");
        restore_n = 1'b1;
`endif

        // Random mix of controls.
        for (int n = 0; n < 60; n++) begin
            reset     = ($urandom_range(0, 15) == 0);
            load_xfer = ($urandom_range(0, 5) != 0);
            load_addr = ($urandom_range(0, 5) != 0);
            load_main = ($urandom_range(0, 3) != 0);
            inc       = ($urandom_range(0, 1) != 0);
            dec       = ($urandom_range(0, 1) != 0);
            lane_sel  = 1'($urandom_range(0, 1));
            assert_main = 1'($urandom_range(0, 1));
            assert_addr = 1'($urandom_range(0, 1));
            xfer_in   = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            addr_in   = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            main_in   = 8'($urandom);
`ifdef REGISTER_XFER_SHADOW_EN
            save_n    = ($urandom_range(0, 3) != 0);
            restore_n = ($urandom_range(0, 4) != 0);
`endif
            cycle("rand");
            chk_comb("rand_comb");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
